// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: parametrised pipelined carry-lookahead adder/subtractor
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  input handshake; in_ready is the global pipeline enable
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored)
//   out_valid, out_ready output handshake
//   s, cout, ovf        sum mod 2^WIDTH, carry out of MSB, signed overflow
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int STAGES = 2,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;
    localparam int NG = SEG / BLOCK;

    // One segment: group generate/propagate, lookahead across groups,
    // then bit carries inside each group from its group carry-in.
    function automatic logic [SEG:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
        logic [SEG-1:0] g, p;
        logic [SEG:0] c;
        logic [NG-1:0] gg, gp;
        g = x & y;
        p = x ^ y;
        c = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+i];
            end
        end
        c[0] = ci;
        for (int j = 0; j < NG; j++)
            c[(j+1)*BLOCK] = gg[j] | (gp[j] & c[j*BLOCK]);
        for (int j = 0; j < NG; j++)
            for (int i = 1; i < BLOCK; i++)
                c[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & c[j*BLOCK+i-1]);
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic en;
    logic ovf_q;

    assign en = !out_valid | out_ready;
    assign in_ready = en;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : st
        localparam int LO = k * SEG;
        logic vi, ci, vq, cq;
        logic [WIDTH-LO-1:0] xin, yin;
        logic [SEG:0] r;
        logic [LO+SEG-1:0] sum_d, lo_q;
        if (k == 0) begin : first
            assign vi = in_valid;
            assign ci = sub | cin;
            assign xin = a;
            assign yin = b ^ {WIDTH{sub}};
            assign sum_d = r[SEG-1:0];
        end else begin : next
            assign vi = st[k-1].vq;
            assign ci = st[k-1].cq;
            assign xin = st[k-1].up.xq;
            assign yin = st[k-1].up.yq;
            assign sum_d = {r[SEG-1:0], st[k-1].lo_q};
        end
        assign r = cla(xin[SEG-1:0], yin[SEG-1:0], ci);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vq <= 1'b0;
                cq <= 1'b0;
                lo_q <= '0;
            end else if (en) begin
                vq <= vi;
                cq <= r[SEG];
                lo_q <= sum_d;
            end
        end
        // Operand bits not yet consumed ride along to later stages.
        if (k < STAGES - 1) begin : up
            logic [WIDTH-LO-SEG-1:0] xq, yq;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    xq <= '0;
                    yq <= '0;
                end else if (en) begin
                    xq <= xin[WIDTH-LO-1:SEG];
                    yq <= yin[WIDTH-LO-1:SEG];
                end
            end
        end
    end

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (en)
            ovf_q <= st[STAGES-1].r[SEG] ^ st[STAGES-1].r[SEG-1] ^ st[STAGES-1].xin[SEG-1] ^ st[STAGES-1].yin[SEG-1];
    end

    assign out_valid = st[STAGES-1].vq;
    assign s = st[STAGES-1].lo_q;
    assign cout = st[STAGES-1].cq;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: self-checking bench over four adder configurations
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst, in_valid, cin, sub;
    logic [63:0] a, b;
    logic [3:0] ordy, ov, ir, co, of;
    logic [31:0] s0, s1;
    logic [15:0] s2;
    logic [63:0] s3;
    logic [63:0] so [4];
    int wdt [4] = '{32, 32, 16, 64};

    logic [65:0] fq [4][64];
    logic [65:0] held [4];
    logic hp [4];
    int wp [4], rp [4], recv [4];
    int vectors = 0, miscompares = 0;
    logic acc0;
    int sent, base, stall;
    logic first, busy;

    always #5 clk = ~clk;

    assign so[0] = {32'd0, s0};
    assign so[1] = {32'd0, s1};
    assign so[2] = {48'd0, s2};
    assign so[3] = s3;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a[31:0]), .b(b[31:0]),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .s(s0), .cout(co[0]), .ovf(of[0]));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .BLOCK(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a[31:0]), .b(b[31:0]),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .s(s1), .cout(co[1]), .ovf(of[1]));
    pipelined_cla_adder #(.WIDTH(16), .STAGES(1), .BLOCK(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a[15:0]), .b(b[15:0]),
        .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .s(s2), .cout(co[2]), .ovf(of[2]));
    pipelined_cla_adder #(.WIDTH(64), .STAGES(8), .BLOCK(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[3]), .out_ready(ordy[3]), .s(s3), .cout(co[3]), .ovf(of[3]));

    // Golden arithmetic: {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [65:0] model(int w, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
        logic [64:0] mk, xm, ym, t;
        mk = (65'd1 << w) - 65'd1;
        xm = {1'b0, x} & mk;
        ym = {1'b0, sb ? ~y : y} & mk;
        t = xm + ym + {64'd0, sb | ci};
        return {(xm[w-1] == ym[w-1]) && (t[w-1] != xm[w-1]), t[w], t[63:0] & mk[63:0]};
    endfunction

    task automatic chk(string tag, logic [66:0] got, logic [66:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard bookkeeping for the coming edge, then advance one clock.
    task automatic cyc();
        #1;
        acc0 = !rst && in_valid && ir[0];
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rp[i] = wp[i];
                hp[i] = 1'b0;
            end else begin
                if (hp[i]) begin
                    chk($sformatf("u%0d_hold", i), {ov[i], of[i], co[i], so[i]}, {1'b1, held[i]});
                    hp[i] = 1'b0;
                end
                if (ov[i] && !ordy[i]) begin
                    hp[i] = 1'b1;
                    held[i] = {of[i], co[i], so[i]};
                end
                if (ov[i] && ordy[i]) begin
                    chk($sformatf("u%0d_sb_nonempty", i), 67'(wp[i] != rp[i]), 67'd1);
                    if (wp[i] != rp[i]) begin
                        chk($sformatf("u%0d_result", i), {1'b0, of[i], co[i], so[i]}, {1'b0, fq[i][rp[i] % 64]});
                        rp[i]++;
                        recv[i]++;
                    end
                end
                if (in_valid && ir[i]) begin
                    fq[i][wp[i] % 64] = model(wdt[i], a, b, cin, sub);
                    wp[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic op_check(logic [31:0] x, logic [31:0] y, logic ci, logic sb, logic [31:0] es, logic ec, logic eo);
        a = {32'd0, x};
        b = {32'd0, y};
        cin = ci;
        sub = sb;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lat_early", 67'(ov[0]), 67'd0);
        cyc();
        chk("lat_valid", 67'(ov[0]), 67'd1);
        chk("dir_s", 67'(s0), 67'(es));
        chk("dir_cout", 67'(co[0]), 67'(ec));
        chk("dir_ovf", 67'(of[0]), 67'(eo));
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wp[i] = 0; rp[i] = 0; recv[i] = 0; hp[i] = 1'b0; held[i] = '0;
        end
        rst = 1'b1; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; a = '0; b = '0; ordy = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 67'(ov), 67'd0);
        chk("rst_s", 67'(s0), 67'd0);
        chk("rst_cout", 67'(co), 67'd0);
        chk("rst_ovf", 67'(of), 67'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 67'(ir), 67'hF);
        @(negedge clk);

        op_check(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        op_check(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        op_check(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        op_check(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        repeat (10) cyc();

        sent = 0; base = recv[0]; stall = 0; first = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
        for (int t = 0; t < 40 && recv[0] - base < 4; t++) begin
            in_valid = sent < 4;
            if (ov[0] && !first) begin
                first = 1'b1;
                stall = 3;
            end
            ordy[0] = stall == 0;
            #1;
            if (stall > 0) begin
                chk("stall_in_ready", 67'(ir[0]), 67'd0);
                stall--;
            end
            cyc();
            if (acc0) begin
                sent++;
                a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        ordy = 4'hF;
        chk("stall_delivered", 67'(recv[0] - base), 67'd4);
        repeat (10) cyc();

        a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'b1;
        cyc();
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_flush_valid", 67'(ov), 67'd0);
        cyc();
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            chk("no_ghost", 67'(ov), 67'd0);
        end
        op_check(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0);

        for (int t = 0; t < 1500; t++) begin
            in_valid = ($urandom % 4) != 0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom % 8 == 0) a = ~64'd0;
            if ($urandom % 8 == 0) b = ($urandom % 2 == 0) ? 64'd0 : 64'h8000000080008000;
            cin = 1'($urandom);
            sub = 1'($urandom);
            ordy = 4'($urandom) | 4'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        ordy = 4'hF;
        busy = 1'b1;
        for (int t = 0; t < 50 && busy; t++) begin
            cyc();
            busy = 1'b0;
            for (int i = 0; i < 4; i++) if (wp[i] != rp[i]) busy = 1'b1;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("u%0d_drained", i), 67'(wp[i] - rp[i]), 67'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
